// File: rtl/imem_boot_loader_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
// Zero latency (constants and a pure function only); no backpressure involved.
package imem_boot_loader_pkg;

    localparam int DATA_WIDTH          = 32;
    localparam int INST_MEM_DEPTH      = 256;
    localparam int INST_MEM_ADDR_WIDTH = $clog2(INST_MEM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    // Replace one byte lane of a word; lane 0 is bits 7:0 (little-endian).
    function automatic logic [DATA_WIDTH-1:0] insert_byte(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [7:0]            value
    );
        logic [DATA_WIDTH-1:0] result;
        result = word;
        for (int i = 0; i < 4; i++) begin
            if (lane == 2'(i)) begin
                result[i*8 +: 8] = value;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/imem_boot_loader_assembler.sv
// Assembles four little-endian bytes into a 32-bit word.
// word_next is combinational (includes the byte on the bus); word_valid flags the 4th byte.
module byte_word_assembler
    import imem_boot_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  byte_fire,
    input  logic [7:0]            byte_data,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  word_valid
);

    logic [1:0]            lane;
    logic [DATA_WIDTH-1:0] word_q;

    // Upper lanes may hold stale bytes until overwritten; only the 4th-byte view is consumed.
    always_comb begin
        word_next = insert_byte(word_q, lane, byte_data);
    end

    assign word_valid = byte_fire && (lane == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane   <= 2'd0;
            word_q <= '0;
        end else if (clr) begin
            lane   <= 2'd0;
            word_q <= '0;
        end else if (byte_fire) begin
            lane   <= lane + 2'd1;
            word_q <= word_next;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: byte stream -> header count + words -> imem write port; holds core until done.
// Latency: write strobe one cycle after a word's 4th byte; 1 word / 5 cycles max.
// Backpressure: byte_ready low outside HDR/DATA/CSUM. Optional IMEM_LOAD_CHECKSUM_EN adds a checksum trailer.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int MAX_WORDS = INST_MEM_DEPTH,
    parameter int CNT_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_i,
    input  logic                           byte_valid_i,
    input  logic [7:0]                     byte_data_i,
    output logic                           byte_ready_o,
    output logic                           wr_en_o,
    output logic [INST_MEM_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0]          wr_data_o,
    output logic                           core_hold_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [INST_MEM_ADDR_WIDTH:0]   words_loaded_o
);

    localparam int                   WCNT_W  = INST_MEM_ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

    loader_state_e state, state_next;

    logic [CNT_WIDTH-1:0]           count_q;
    logic [WCNT_W-1:0]              word_cnt;
    logic [WCNT_W-1:0]              word_cnt_inc;
    logic [INST_MEM_ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]          wr_data_q;
    logic [DATA_WIDTH-1:0]          asm_next;
    logic [CNT_WIDTH-1:0]           hdr_cnt;
    logic                           asm_vld;
    logic                           asm_clr;
    logic                           byte_fire;
    logic                           last_word;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
`endif

    assign byte_fire    = byte_valid_i && byte_ready_o;
    assign hdr_cnt      = asm_next[CNT_WIDTH-1:0];
    assign word_cnt_inc = word_cnt + WCNT_W'(1);
    assign last_word    = (CNT_WIDTH'(word_cnt_inc) == count_q);

    byte_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (asm_clr),
        .byte_fire  (byte_fire),
        .byte_data  (byte_data_i),
        .word_next  (asm_next),
        .word_valid (asm_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        core_hold_o  = 1'b1;
        wr_en_o      = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        asm_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = HDR;
                    asm_clr    = 1'b1;
                end
            end
            HDR: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (asm_vld) begin
                    if (hdr_cnt == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end else if (hdr_cnt > MAX_CNT) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (asm_vld) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy_o  = 1'b1;
                wr_en_o = 1'b1;
                if (last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end else begin
                    state_next = DATA;
                end
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            CSUM: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (asm_vld) begin
                    state_next = (asm_next == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE: begin
                done_o      = 1'b1;
                core_hold_o = 1'b0;
                if (start_i) begin
                    state_next  = HDR;
                    core_hold_o = 1'b1;
                    asm_clr     = 1'b1;
                end
            end
            ERR: begin
                err_o = 1'b1;
                if (start_i) begin
                    state_next = HDR;
                    asm_clr    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address/data are captured with the 4th byte so they are stable throughout WRITE and hold after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            word_cnt  <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (asm_clr) begin
                word_cnt <= '0;
            end
            if (state == HDR && asm_vld) begin
                count_q <= hdr_cnt;
            end
            if (state == DATA && asm_vld) begin
                wr_addr_q <= word_cnt[INST_MEM_ADDR_WIDTH-1:0];
                wr_data_q <= asm_next;
            end
            if (state == WRITE) begin
                word_cnt <= word_cnt_inc;
            end
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (asm_clr) begin
            csum_q <= '0;
        end else if (state == WRITE) begin
            csum_q <= csum_q + wr_data_q;
        end
    end
`endif

    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign words_loaded_o = word_cnt;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized scoreboard bench for imem_boot_loader; expected writes queued at stimulus time.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int MAXW = 16;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic                           start = 1'b0;
    logic                           byte_valid = 1'b0;
    logic [7:0]                     byte_data = 8'h00;
    logic                           byte_ready;
    logic                           wr_en;
    logic [INST_MEM_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           core_hold;
    logic                           busy;
    logic                           done;
    logic                           err;
    logic [INST_MEM_ADDR_WIDTH:0]   words_loaded;

    imem_boot_loader #(.MAX_WORDS(MAXW), .CNT_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .byte_valid_i   (byte_valid),
        .byte_data_i    (byte_data),
        .byte_ready_o   (byte_ready),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data),
        .core_hold_o    (core_hold),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .words_loaded_o (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INST_MEM_ADDR_WIDTH-1:0] addr;
        logic [31:0]                    data;
    } wr_t;

    wr_t         sb[$];
    logic [7:0]  stream[$];
    logic [31:0] words[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc_cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("wr_latency", cyc - acc_cyc, 1);
                chk("ready_in_write", byte_ready, 0);
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream.push_back(w[i*8 +: 8]);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        #1;
        chk("hold_on_start", core_hold, 1);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive the byte stream with random idle gaps; start is pulsed randomly while busy to prove it is ignored.
    task automatic send_stream(input int gap_pct);
        int   idx = 0;
        int   budget = 0;
        int   c;
        logic rdy;
        while (idx < stream.size()) begin
            byte_valid = ($urandom_range(99) >= gap_pct);
            byte_data  = byte_valid ? stream[idx] : 8'($urandom);
            start      = (gap_pct > 0) && (idx < stream.size() - 1) && ($urandom_range(7) == 0);
            @(negedge clk);
            rdy = byte_ready;
            c   = cyc;
            @(posedge clk); #1;
            if (byte_valid && rdy) begin
                idx++;
                acc_cyc = c;
            end
            budget++;
            if (budget > 2000) begin
                chk("stream_timeout", 1, 0);
                break;
            end
        end
        byte_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy === 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (busy !== 1'b0) chk("idle_timeout", 1, 0);
    endtask

    // Reference model: header/overflow/checksum rules applied directly to the word list.
    task automatic do_load(input logic [31:0] n_hdr, input int gap_pct, input bit bad_sum);
        logic [31:0] sum;
        bit          ok;
        int          exp_loaded;
        sum = 0;
        stream.delete();
        push_word(n_hdr);
        if (n_hdr > MAXW) begin
            ok         = 0;
            exp_loaded = 0;
        end else begin
            for (int i = 0; i < int'(n_hdr); i++) begin
                push_word(words[i]);
                sb.push_back('{addr: INST_MEM_ADDR_WIDTH'(i), data: words[i]});
                sum += words[i];
            end
`ifdef IMEM_LOAD_CHECKSUM_EN
            push_word(bad_sum ? (sum ^ 32'h1) : sum);
            ok = !bad_sum;
`else
            ok = !(bad_sum && 1'b0);
`endif
            exp_loaded = int'(n_hdr);
        end
        pulse_start();
        send_stream(gap_pct);
        wait_idle();
        chk("done", done, ok);
        chk("err", err, !ok);
        chk("core_hold", core_hold, !ok);
        chk("words_loaded", words_loaded, exp_loaded);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_vals();
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_core_hold", core_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_words_loaded", words_loaded, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        check_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        words = '{32'h0000_0013, 32'h0010_0093};
        do_load(32'd2, 0, 1'b0);
        chk("wr_addr_holds", wr_addr, 1);

        words.delete();
        do_load(32'd0, 0, 1'b0);
        do_load(32'(MAXW + 1), 0, 1'b0);

        words = '{32'h0000_0013, 32'h0010_0093};
        do_load(32'd2, 50, 1'b0);
`ifdef IMEM_LOAD_CHECKSUM_EN
        do_load(32'd2, 0, 1'b1);
`endif

        // Abandon a load after the first word, then reload from scratch.
        stream.delete();
        push_word(32'd2);
        push_word(words[0]);
        sb.push_back('{addr: '0, data: words[0]});
        pulse_start();
        send_stream(0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_words_loaded", words_loaded, 1);
        chk("mid_sb_drained", sb.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_load(32'd2, 0, 1'b0);

        do_load(32'(MAXW), 30, 1'b0);

        for (int r = 0; r < 24; r++) begin
            logic [31:0] n;
            bit          bad;
            n = 32'($urandom_range(0, MAXW));
            if (r % 7 == 6) n = 32'(MAXW + 1) + $urandom_range(0, 100000);
            words.delete();
            for (int i = 0; i < MAXW; i++) words.push_back($urandom);
            bad = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            bad = ($urandom_range(3) == 0);
`endif
            do_load(n, $urandom_range(0, 60), bad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
